pipe_gen: RTL

- Generates and scrolls the two pipe obstacles for the playfield.
- Drives xPipe0/xPipe1 (right edge of each pipe, in px) and yPipe0/yPipe1 (bottom edge of each gap, in px) straight into the collision/score checker.
- Consumes that checker's registered `dead` flag to freeze the scene.
- Scroll is exactly 1 px per step, so every pipe passes through x = 80 and x = 81 and the checker scores it exactly once.

---
 rtl/pipe_gen.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/pipe_gen.sv
// pipe_gen: generates and scrolls the two pipe obstacles of the playfield.
// Each pipe is described by its right-edge x and the bottom y of its gap.
// Both pipes move left by exactly 1 px per scroll step, so every pipe passes
// through every column and the downstream checker scores it exactly once.
// A pipe that has reached x = 0 respawns off-screen right on the next step,
// and its gap height is taken from a free-running 16-bit LFSR.
// The registered collision flag `dead` freezes the whole scene.
//
// Optional build macro: SPEEDUP_EN
//   When defined, every 8 respawns shorten the scroll step period by
//   STEP_DIV/8 clk cycles. The period never drops below STEP_DIV/4.
//   When undefined, the step period is fixed at STEP_DIV clk cycles.
module pipe_gen #(
    parameter int unsigned STEP_DIV = 200000,
    parameter int unsigned SPAWN_X  = 670,
    parameter int unsigned SPACING  = 335,
    parameter int unsigned Y_MIN    = 180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        pause,
    input  logic        dead,
    output logic [10:0] xPipe0,
    output logic [10:0] xPipe1,
    output logic [10:0] yPipe0,
    output logic [10:0] yPipe1,
    output logic        step,
    output logic        respawn
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_OVER = 2'd3
    } state_t;

    // Geometry and timing constants at their datapath widths.
    localparam logic [10:0] SPAWN_X0_W = 11'(SPAWN_X);
    localparam logic [10:0] SPAWN_X1_W = 11'(SPAWN_X + SPACING);
    localparam logic [10:0] Y_MIN_W    = 11'(Y_MIN);
    localparam logic [10:0] Y0_INIT    = 11'd300;
    localparam logic [10:0] Y1_INIT    = 11'd260;
    localparam logic [17:0] STEP_DIV_W = 18'(STEP_DIV);
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;

`ifdef SPEEDUP_EN
    localparam logic [17:0] DIV_DEC_W   = 18'(STEP_DIV / 8);
    localparam logic [17:0] DIV_FLOOR_W = 18'(STEP_DIV / 4);
`endif

    // One Fibonacci LFSR shift, polynomial x^16 + x^14 + x^13 + x^11 + 1.
    // A non-zero seed can never reach the all-zero lock-up state.
    function automatic logic [15:0] lfsr_advance(input logic [15:0] cur);
        logic fb;
        fb = cur[15] ^ cur[13] ^ cur[12] ^ cur[10];
        return {cur[14:0], fb};
    endfunction

    // Gap bottom for a freshly spawned pipe: Y_MIN .. Y_MIN + 255.
    function automatic logic [10:0] gap_bottom(input logic [15:0] cur);
        return Y_MIN_W + {3'b000, cur[7:0]};
    endfunction

`ifdef SPEEDUP_EN
    // Shorter step period after a completed group of respawns, never below the floor.
    function automatic logic [17:0] next_divisor(input logic [17:0] cur);
        logic [17:0] res;
        if (cur >= (DIV_FLOOR_W + DIV_DEC_W)) begin
            res = cur - DIV_DEC_W;
        end else begin
            res = DIV_FLOOR_W;
        end
        return res;
    endfunction
`endif

    state_t      state_r;
    state_t      state_next_s;
    logic [15:0] lfsr_r;
    logic [17:0] div_r;
    logic [17:0] div_next_s;
    logic [17:0] div_last_s;
    logic [10:0] x0_r;
    logic [10:0] x1_r;
    logic [10:0] y0_r;
    logic [10:0] y1_r;
    logic [10:0] x0_next_s;
    logic [10:0] x1_next_s;
    logic [10:0] y0_next_s;
    logic [10:0] y1_next_s;
    logic        step_r;
    logic        respawn_r;
    logic        run_tick_s;
    logic        step_s;
    logic        respawn_s;
    logic        pipe0_spawn_s;
    logic        pipe1_spawn_s;

`ifdef SPEEDUP_EN
    logic [2:0]  respawn_cnt_r;
    logic [17:0] div_target_r;
    logic [17:0] div_active_r;

    // The active divisor only changes at a divider wrap, so a period is never cut short.
    assign div_last_s = div_active_r - 18'd1;
`else
    assign div_last_s = STEP_DIV_W - 18'd1;
`endif

    // State register; reset forces IDLE from any state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; run_tick_s marks a RUN cycle with no transition pending.
    always_comb begin
        state_next_s = state_r;
        run_tick_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (enable && !pause && !dead) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_next_s = ST_IDLE;
                end else if (dead) begin
                    state_next_s = ST_OVER;
                end else if (pause) begin
                    state_next_s = ST_HOLD;
                end else begin
                    state_next_s = ST_RUN;
                    run_tick_s   = 1'b1;
                end
            end
            ST_HOLD: begin
                if (!enable) begin
                    state_next_s = ST_IDLE;
                end else if (dead) begin
                    state_next_s = ST_OVER;
                end else if (!pause) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            ST_OVER: begin
                if (!enable) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_OVER;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Divider and pipe positions; a step is taken only on an undisturbed terminal count.
    always_comb begin
        div_next_s    = div_r;
        x0_next_s     = x0_r;
        x1_next_s     = x1_r;
        y0_next_s     = y0_r;
        y1_next_s     = y1_r;
        step_s        = run_tick_s && (div_r == div_last_s);
        pipe0_spawn_s = (x0_r == 11'd0);
        pipe1_spawn_s = (x1_r == 11'd0);
        respawn_s     = step_s && (pipe0_spawn_s || pipe1_spawn_s);

        if (state_next_s == ST_IDLE) begin
            // Entering or sitting in IDLE re-initialises the scene.
            div_next_s = 18'd0;
            x0_next_s  = SPAWN_X0_W;
            x1_next_s  = SPAWN_X1_W;
            y0_next_s  = Y0_INIT;
            y1_next_s  = Y1_INIT;
        end else if (step_s) begin
            div_next_s = 18'd0;
            if (pipe0_spawn_s) begin
                x0_next_s = SPAWN_X0_W;
                y0_next_s = gap_bottom(lfsr_r);
            end else begin
                x0_next_s = x0_r - 11'd1;
                y0_next_s = y0_r;
            end
            if (pipe1_spawn_s) begin
                x1_next_s = SPAWN_X0_W;
                y1_next_s = gap_bottom(lfsr_r);
            end else begin
                x1_next_s = x1_r - 11'd1;
                y1_next_s = y1_r;
            end
        end else if (run_tick_s) begin
            div_next_s = div_r + 18'd1;
        end else begin
            // HOLD, OVER, and transition cycles freeze the divider and positions.
            div_next_s = div_r;
        end
    end

    // Datapath and output registers; step/respawn are single-cycle pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_r     <= 18'd0;
            x0_r      <= SPAWN_X0_W;
            x1_r      <= SPAWN_X1_W;
            y0_r      <= Y0_INIT;
            y1_r      <= Y1_INIT;
            step_r    <= 1'b0;
            respawn_r <= 1'b0;
        end else begin
            div_r     <= div_next_s;
            x0_r      <= x0_next_s;
            x1_r      <= x1_next_s;
            y0_r      <= y0_next_s;
            y1_r      <= y1_next_s;
            step_r    <= step_s;
            respawn_r <= respawn_s;
        end
    end

    // Free-running gap-height generator; advances every cycle outside reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_r <= LFSR_SEED;
        end else begin
            lfsr_r <= lfsr_advance(lfsr_r);
        end
    end

`ifdef SPEEDUP_EN
    // Speed-up bookkeeping: count respawns, shrink the target divisor every 8th,
    // and hand the target over to the active divisor at each divider wrap.
    always_ff @(posedge clk) begin
        if (reset || (state_next_s == ST_IDLE)) begin
            respawn_cnt_r <= 3'd0;
            div_target_r  <= STEP_DIV_W;
            div_active_r  <= STEP_DIV_W;
        end else begin
            if (respawn_s) begin
                respawn_cnt_r <= respawn_cnt_r + 3'd1;
                if (respawn_cnt_r == 3'd7) begin
                    div_target_r <= next_divisor(div_target_r);
                end else begin
                    div_target_r <= div_target_r;
                end
            end else begin
                respawn_cnt_r <= respawn_cnt_r;
                div_target_r  <= div_target_r;
            end
            if (step_s) begin
                div_active_r <= div_target_r;
            end else begin
                div_active_r <= div_active_r;
            end
        end
    end
`endif

    assign xPipe0  = x0_r;
    assign xPipe1  = x1_r;
    assign yPipe0  = y0_r;
    assign yPipe1  = y1_r;
    assign step    = step_r;
    assign respawn = respawn_r;

endmodule
